// File: rtl/data_memory_stage.sv
// Memory-access stage: word-organised data RAM with byte-lane stores, extending loads,
// misalignment detection and an optional wait-state FSM that stalls the pipeline.
module data_memory_stage #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        MisalignSticky
);
    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] WS     = 4'(WAIT_STATES);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wordIdx;
    logic [1:0]    off;
    logic          isLoad;
    logic          req;
    logic          isHalf;
    logic          isWord;
    logic          misAcc;
    logic          storeF3Ok;
    logic          commit;
    logic [3:0]    byteEn;
    logic [31:0]   storeData;
    logic [31:0]   rdWord;
    logic [0:0]    state;
    logic [0:0]    nextState;
    logic [3:0]    cnt;
    logic [3:0]    nextCnt;
    logic          stallRaw;
    logic          unusedAddrHi;

    function automatic logic [31:0] extendLoad(input logic [2:0]  f3,
                                               input logic [31:0] word,
                                               input logic [1:0]  byteOff);
        logic signed [7:0]  sByte;
        logic signed [15:0] sHalf;
        logic signed [31:0] ext;
        sByte = 8'(word >> {byteOff, 3'b000});
        sHalf = 16'(word >> {byteOff[1], 4'b0000});
        case (f3)
            3'b000:  ext = 32'(sByte);
            3'b001:  ext = 32'(sHalf);
            3'b010:  ext = word;
            3'b100:  ext = {24'b0, sByte};
            3'b101:  ext = {16'b0, sHalf};
            default: ext = '0;
        endcase
        return ext;
    endfunction

    // Upper address bits are deliberately ignored so accesses wrap modulo the RAM size.
    assign wordIdx      = ALUResultM[AW+1:2];
    assign off          = ALUResultM[1:0];
    assign unusedAddrHi = ^ALUResultM[31:AW+2];

    assign isLoad    = (ResultSrcM == 2'b01);
    assign req       = MemWriteM || isLoad;
    assign isHalf    = (funct3M == 3'b001) || (funct3M == 3'b101);
    assign isWord    = (funct3M == 3'b010);
    assign misAcc    = (isHalf && off[0]) || (isWord && (off != 2'b00));
    assign MisalignM = req && misAcc;

    assign rdWord    = mem[wordIdx];
    assign ReadDataM = (isLoad && !misAcc) ? extendLoad(funct3M, rdWord, off) : '0;

    always_comb begin
        byteEn    = 4'b0000;
        storeData = WriteDataM;
        storeF3Ok = 1'b0;
        case (funct3M)
            3'b000: begin
                byteEn    = 4'b0001 << off;
                storeData = {4{WriteDataM[7:0]}};
                storeF3Ok = 1'b1;
            end
            3'b001: begin
                byteEn    = 4'b0011 << off;
                storeData = {2{WriteDataM[15:0]}};
                storeF3Ok = 1'b1;
            end
            3'b010: begin
                byteEn    = 4'b1111;
                storeF3Ok = 1'b1;
            end
            default: ;
        endcase
    end

    // Stores land only in the completion cycle; a reset pulse discards a pending store.
    assign commit = rst_n && MemWriteM && !StallM && !misAcc && storeF3Ok;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) mem[wordIdx][8*b +: 8] <= storeData[8*b +: 8];
            end
        end
    end

    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        stallRaw  = 1'b0;
        if (WAIT_STATES != 0) begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        stallRaw  = 1'b1;
                        nextState = S_WAIT;
                        nextCnt   = 4'd1;
                    end
                end
                default: begin
                    if (cnt < WS) begin
                        stallRaw = 1'b1;
                        nextCnt  = cnt + 4'd1;
                    end else begin
                        nextState = S_IDLE;
                        nextCnt   = '0;
                    end
                end
            endcase
        end
    end

    // Gating with rst_n lets the stall drop immediately when reset asserts mid-wait.
    assign StallM = stallRaw && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            MisalignSticky <= 1'b0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            if (MisalignM) MisalignSticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_data_memory_stage.sv
// Scoreboard bench for data_memory_stage: three instances (0, 2 and 3 wait states).
module tb_data_memory_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN      [3];
    logic        memWrite  [3];
    logic [1:0]  resultSrc [3];
    logic [2:0]  funct3    [3];
    logic [31:0] aluResult [3];
    logic [31:0] writeData [3];
    logic [31:0] readData  [3];
    logic        stall     [3];
    logic        misalign  [3];
    logic        sticky    [3];

    int          nChecks = 0;
    int          nErrors = 0;
    logic [31:0] expQ[$];

    data_memory_stage #(.DEPTH(1024), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst_n(rstN[0]), .MemWriteM(memWrite[0]), .ResultSrcM(resultSrc[0]),
        .funct3M(funct3[0]), .ALUResultM(aluResult[0]), .WriteDataM(writeData[0]),
        .ReadDataM(readData[0]), .StallM(stall[0]), .MisalignM(misalign[0]),
        .MisalignSticky(sticky[0]));

    data_memory_stage #(.DEPTH(1024), .WAIT_STATES(2)) u1 (
        .clk(clk), .rst_n(rstN[1]), .MemWriteM(memWrite[1]), .ResultSrcM(resultSrc[1]),
        .funct3M(funct3[1]), .ALUResultM(aluResult[1]), .WriteDataM(writeData[1]),
        .ReadDataM(readData[1]), .StallM(stall[1]), .MisalignM(misalign[1]),
        .MisalignSticky(sticky[1]));

    data_memory_stage #(.DEPTH(1024), .WAIT_STATES(3)) u2 (
        .clk(clk), .rst_n(rstN[2]), .MemWriteM(memWrite[2]), .ResultSrcM(resultSrc[2]),
        .funct3M(funct3[2]), .ALUResultM(aluResult[2]), .WriteDataM(writeData[2]),
        .ReadDataM(readData[2]), .StallM(stall[2]), .MisalignM(misalign[2]),
        .MisalignSticky(sticky[2]));

    task automatic idle(input int k);
        memWrite[k]  = 1'b0;
        resultSrc[k] = 2'b00;
        funct3[k]    = 3'b000;
        aluResult[k] = 32'h0;
        writeData[k] = 32'h0;
    endtask

    // Drives one access, holds it through the stall and returns after the completion edge.
    task automatic doAccess(input int k, input logic w, input logic ld, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] expRd, output int stallCycles, output logic misObs);
        bit done;
        expQ.push_back(expRd);
        memWrite[k]  = w;
        resultSrc[k] = ld ? 2'b01 : 2'b00;
        funct3[k]    = f3;
        aluResult[k] = addr;
        writeData[k] = wd;
        stallCycles  = 0;
        misObs       = 1'b0;
        done         = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!stall[k]) begin
                misObs = misalign[k];
                done   = 1'b1;
            end else begin
                stallCycles++;
            end
        end
        if (!done) begin
            nChecks++;
            nErrors++;
            $display("FAIL access_timeout inst=%0d addr=%h stalled %0d cycles, required completion", k, addr, stallCycles);
        end
        @(posedge clk);
        #1;
        idle(k);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            rstN[k] = 1'b0;
            idle(k);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            nChecks++;
            if (stall[k] !== 1'b0) begin
                nErrors++;
                $display("FAIL reset_stall inst=%0d got=%b expected=0", k, stall[k]);
            end
            nChecks++;
            if (sticky[k] !== 1'b0) begin
                nErrors++;
                $display("FAIL reset_sticky inst=%0d got=%b expected=0", k, sticky[k]);
            end
            nChecks++;
            if (readData[k] !== 32'h0 || misalign[k] !== 1'b0) begin
                nErrors++;
                $display("FAIL reset_idle_outputs inst=%0d got rd=%h mis=%b expected rd=0 mis=0", k, readData[k], misalign[k]);
            end
        end
        resultSrc[1] = 2'b01;
        funct3[1]    = 3'b010;
        #1;
        nChecks++;
        if (stall[1] !== 1'b0) begin
            nErrors++;
            $display("FAIL reset_req_no_stall got=%b expected=0", stall[1]);
        end
        idle(1);
        @(negedge clk);
        for (int k = 0; k < 3; k++) rstN[k] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_cycle();
        int sc;
        logic mis;
        doAccess(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, sc, mis);
        nChecks++;
        if (sc !== 0) begin
            nErrors++;
            $display("FAIL ws0_store_stall got=%0d expected=0", sc);
        end
        doAccess(0, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, sc, mis);
        nChecks++;
        if (sc !== 0 || mis !== 1'b0) begin
            nErrors++;
            $display("FAIL ws0_load got stall=%0d mis=%b expected stall=0 mis=0", sc, mis);
        end
    endtask

    task automatic test_byte_half();
        int sc;
        logic mis;
        doAccess(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h11223344, 32'h0, sc, mis);
        doAccess(0, 1'b1, 1'b0, 3'b000, 32'h13, 32'h00000080, 32'h0, sc, mis);
        doAccess(0, 1'b0, 1'b1, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, sc, mis);
        doAccess(0, 1'b0, 1'b1, 3'b100, 32'h13, 32'h0, 32'h00000080, sc, mis);
        doAccess(0, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 32'h80223344, sc, mis);
        doAccess(0, 1'b0, 1'b1, 3'b001, 32'h12, 32'h0, 32'hFFFF8022, sc, mis);
        doAccess(0, 1'b0, 1'b1, 3'b101, 32'h12, 32'h0, 32'h00008022, sc, mis);
        doAccess(0, 1'b0, 1'b1, 3'b000, 32'h10, 32'h0, 32'h00000044, sc, mis);
        doAccess(0, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0000BEEF, 32'h0, sc, mis);
        nChecks++;
        if (mis !== 1'b0) begin
            nErrors++;
            $display("FAIL sh_aligned_misalign got=%b expected=0", mis);
        end
        doAccess(0, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 32'hBEEF3344, sc, mis);
    endtask

    task automatic test_misalign();
        int sc;
        logic mis;
        nChecks++;
        if (sticky[0] !== 1'b0) begin
            nErrors++;
            $display("FAIL sticky_before got=%b expected=0", sticky[0]);
        end
        doAccess(0, 1'b1, 1'b0, 3'b001, 32'h11, 32'h0000ABCD, 32'h0, sc, mis);
        nChecks++;
        if (mis !== 1'b1) begin
            nErrors++;
            $display("FAIL sh_misalign_flag got=%b expected=1", mis);
        end
        nChecks++;
        if (sticky[0] !== 1'b1) begin
            nErrors++;
            $display("FAIL sticky_set got=%b expected=1", sticky[0]);
        end
        doAccess(0, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 32'hBEEF3344, sc, mis);
        nChecks++;
        if (mis !== 1'b0) begin
            nErrors++;
            $display("FAIL lw_aligned_misalign got=%b expected=0", mis);
        end
        doAccess(0, 1'b0, 1'b1, 3'b010, 32'h12, 32'h0, 32'h0, sc, mis);
        nChecks++;
        if (mis !== 1'b1) begin
            nErrors++;
            $display("FAIL lw_misalign_flag got=%b expected=1", mis);
        end
        doAccess(0, 1'b0, 1'b1, 3'b101, 32'h13, 32'h0, 32'h0, sc, mis);
        nChecks++;
        if (sticky[0] !== 1'b1) begin
            nErrors++;
            $display("FAIL sticky_hold got=%b expected=1", sticky[0]);
        end
        rstN[0] = 1'b0;
        #1;
        nChecks++;
        if (sticky[0] !== 1'b0) begin
            nErrors++;
            $display("FAIL sticky_clear got=%b expected=0", sticky[0]);
        end
        @(posedge clk);
        #1;
        rstN[0] = 1'b1;
    endtask

    task automatic test_invalid_funct3();
        int sc;
        logic mis;
        doAccess(0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h12345678, 32'h0, sc, mis);
        doAccess(0, 1'b1, 1'b0, 3'b011, 32'h20, 32'hFFFFFFFF, 32'h0, sc, mis);
        doAccess(0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 32'h12345678, sc, mis);
        doAccess(0, 1'b0, 1'b1, 3'b011, 32'h20, 32'h0, 32'h0, sc, mis);
        doAccess(0, 1'b0, 1'b1, 3'b110, 32'h20, 32'h0, 32'h0, sc, mis);
        doAccess(0, 1'b0, 1'b1, 3'b111, 32'h20, 32'h0, 32'h0, sc, mis);
    endtask

    task automatic test_store_and_load();
        int sc;
        logic mis;
        doAccess(0, 1'b1, 1'b0, 3'b010, 32'h40, 32'hAABBCCDD, 32'h0, sc, mis);
        doAccess(0, 1'b1, 1'b1, 3'b010, 32'h40, 32'h01020304, 32'hAABBCCDD, sc, mis);
        doAccess(0, 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 32'h01020304, sc, mis);
    endtask

    task automatic test_wrap();
        int sc;
        logic mis;
        doAccess(0, 1'b1, 1'b0, 3'b010, 32'h1000, 32'h00000005, 32'h0, sc, mis);
        doAccess(0, 1'b0, 1'b1, 3'b010, 32'h0, 32'h0, 32'h00000005, sc, mis);
    endtask

    task automatic test_back_to_back();
        int sc;
        logic mis;
        doAccess(1, 1'b1, 1'b0, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, sc, mis);
        nChecks++;
        if (sc !== 2) begin
            nErrors++;
            $display("FAIL ws2_store_stall got=%0d expected=2", sc);
        end
        doAccess(1, 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, sc, mis);
        nChecks++;
        if (sc !== 2) begin
            nErrors++;
            $display("FAIL ws2_load_stall got=%0d expected=2", sc);
        end
        doAccess(1, 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, sc, mis);
        nChecks++;
        if (sc !== 2) begin
            nErrors++;
            $display("FAIL ws2_b2b_stall got=%0d expected=2", sc);
        end
        doAccess(1, 1'b1, 1'b0, 3'b000, 32'h41, 32'h00000011, 32'h0, sc, mis);
        doAccess(1, 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 32'hCAFE110D, sc, mis);
        @(negedge clk);
        nChecks++;
        if (stall[1] !== 1'b0) begin
            nErrors++;
            $display("FAIL ws2_idle_stall got=%b expected=0", stall[1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_wait();
        int sc;
        logic mis;
        doAccess(2, 1'b1, 1'b0, 3'b010, 32'h80, 32'h11111111, 32'h0, sc, mis);
        nChecks++;
        if (sc !== 3) begin
            nErrors++;
            $display("FAIL ws3_store_stall got=%0d expected=3", sc);
        end
        memWrite[2]  = 1'b1;
        funct3[2]    = 3'b010;
        aluResult[2] = 32'h80;
        writeData[2] = 32'h22222222;
        @(negedge clk);
        nChecks++;
        if (stall[2] !== 1'b1) begin
            nErrors++;
            $display("FAIL ws3_stall_c1 got=%b expected=1", stall[2]);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        nChecks++;
        if (stall[2] !== 1'b1) begin
            nErrors++;
            $display("FAIL ws3_stall_c2 got=%b expected=1", stall[2]);
        end
        rstN[2] = 1'b0;
        #1;
        nChecks++;
        if (stall[2] !== 1'b0) begin
            nErrors++;
            $display("FAIL ws3_reset_drop got=%b expected=0", stall[2]);
        end
        idle(2);
        @(posedge clk);
        #1;
        rstN[2] = 1'b1;
        doAccess(2, 1'b0, 1'b1, 3'b010, 32'h80, 32'h0, 32'h11111111, sc, mis);
        nChecks++;
        if (sc !== 3) begin
            nErrors++;
            $display("FAIL ws3_fresh_after_reset got=%0d expected=3", sc);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rstN[k] = 1'b0;
            idle(k);
        end
        fork
            begin
                logic [31:0] expV;
                forever begin
                    @(negedge clk);
                    for (int k = 0; k < 3; k++) begin
                        if (rstN[k] && (memWrite[k] || resultSrc[k] == 2'b01) && !stall[k]) begin
                            nChecks++;
                            if (expQ.size() == 0) begin
                                nErrors++;
                                $display("FAIL scoreboard_unexpected inst=%0d got=%h expected no completion", k, readData[k]);
                            end else begin
                                expV = expQ.pop_front();
                                if (readData[k] !== expV) begin
                                    nErrors++;
                                    $display("FAIL read_data inst=%0d addr=%h f3=%b got=%h expected=%h",
                                             k, aluResult[k], funct3[k], readData[k], expV);
                                end
                            end
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_single_cycle();
        test_byte_half();
        test_misalign();
        test_invalid_funct3();
        test_store_and_load();
        test_wrap();
        test_back_to_back();
        test_reset_mid_wait();
        nChecks++;
        if (expQ.size() != 0) begin
            nErrors++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule

// File: doc/data_memory_stage.md
# data_memory_stage

Memory-access stage of the five-stage RISC-V pipeline. It sits directly downstream of the EX/MEM pipeline register, consuming its M-stage control and data outputs, and presents load data to the MEM/WB register. It holds a word-organised data RAM with byte-lane stores, sign/zero-extending loads, misalignment detection, and an optional wait-state FSM that stalls the pipeline.

## Interface
- DEPTH, 1024: data RAM size in 32-bit words; power of two, at least 4. AW = log2(DEPTH).
- WAIT_STATES, 0: extra cycles per memory access; 0 means single-cycle access, range 0..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- MemWriteM  in  1  store request.
- ResultSrcM  in  2  result select; 2'b01 marks a load.
- funct3M  in  3  access size/sign, RISC-V funct3 encoding.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, right-aligned.
- ReadDataM  out  32  extended load data, combinational.
- StallM  out  1  pipeline stall request, combinational.
- MisalignM  out  1  current access is misaligned, combinational.
- MisalignSticky  out  1  set on any misaligned access; cleared only by reset.

## Operation
- A request (req) is MemWriteM=1 or ResultSrcM=2'b01. If both are set, the access is treated as a store. ReadDataM still shows the pre-write data.
- Word index is ALUResultM[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4. Byte offset is off = ALUResultM[1:0].
- Store sizes:
  - funct3 000 (SB): byte lane off gets WriteDataM[7:0].
  - 001 (SH): lanes off and off+1 get WriteDataM[15:0].
  - 010 (SW): all four lanes get WriteDataM.
  - Any other funct3 on a store: no write.
- Load extension:
  - 000 (LB): sign-extend.
  - 001 (LH): sign-extend.
  - 010 (LW): full word.
  - 100 (LBU): zero-extend.
  - 101 (LHU): zero-extend.
  - Other funct3, or no load: ReadDataM = 0.
- Byte order is little-endian: lane 0 is bits [7:0].
- Misaligned conditions: a halfword access with off[0]=1, or a word access with off≠0.
  - MisalignM=1 only while req is asserted.
  - A misaligned store writes nothing.
  - A misaligned load returns ReadDataM = 0.
- The RAM is read combinationally, giving read-before-write in the same cycle. RAM contents are not cleared by reset.
- Wait-state FSM (only when WAIT_STATES>0), with states IDLE and WAIT and a 4-bit counter cnt:
  - IDLE, no req: StallM=0.
  - IDLE, req: StallM=1, go to WAIT, cnt←1.
  - WAIT, cnt<WAIT_STATES: StallM=1, cnt←cnt+1.
  - WAIT, cnt==WAIT_STATES: StallM=0 (the completion cycle), go to IDLE.
- With WAIT_STATES=0 the FSM stays in IDLE and StallM is tied to 0.
- While StallM=1, upstream holds all inputs stable. Inputs that change mid-wait are undefined behaviour, not checked.
- A store commits only at the rising edge ending a cycle where StallM=0, MemWriteM=1, the access is aligned, and funct3 is valid.

## Timing
- Reset values:
  - FSM in IDLE, cnt=0.
  - StallM=0, MisalignSticky=0.
  - MisalignM and ReadDataM follow their inputs combinationally and are 0 when there is no req.
- Access latency is WAIT_STATES+1 cycles. StallM is high for the first WAIT_STATES cycles of each access.
- Load data is valid in the completion cycle and is captured by MEM/WB at that cycle's edge.
- Back-to-back accesses: a req in the cycle after a completion starts a fresh wait sequence, with no idle gap.
- Reset asserted mid-WAIT: the FSM returns to IDLE immediately and StallM drops asynchronously. The pending store is discarded.
- MisalignSticky sets at the rising edge of any cycle with MisalignM=1, including stalled cycles.

## Test plan
- WAIT_STATES=0: SW 0xDEADBEEF to 0x10, then LW from 0x10 → ReadDataM=0xDEADBEEF, StallM always 0.
- SB 0x80 to 0x13 over word 0x11223344, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LW 0x10 → 0x80223344.
- SH 0xABCD to 0x11 → MisalignM=1, no write (LW 0x10 unchanged), MisalignSticky=1 until rst_n low.
- WAIT_STATES=2: LW request → StallM=1,1,0 over three cycles, data valid in the third. A second back-to-back LW → StallM=1 again in cycle 4.
- WAIT_STATES=3: assert SW, pulse rst_n low during the second stall cycle → StallM=0 at once, FSM in IDLE, target word unchanged.
- Address wrap, DEPTH=1024: SW 0x5 to 0x1000, LW 0x0 → 0x00000005.
